// File: rtl/stage_sequencer_pkg.sv
// Shared encodings for the stage sequencer: FSM states, level codes and
// per-level step periods (in beats).
package stage_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_COUNTDOWN = 3'd1,
    ST_PLAY      = 3'd2,
    ST_PAUSE     = 3'd3,
    ST_RESULT    = 3'd4
  } stage_state_e;

  localparam logic [1:0] LVL_EASY   = 2'd1;
  localparam logic [1:0] LVL_NORMAL = 2'd2;
  localparam logic [1:0] LVL_HARD   = 2'd3;

  localparam int EASY_PERIOD   = 4;
  localparam int NORMAL_PERIOD = 2;
  localparam int HARD_PERIOD   = 1;

  function automatic logic level_valid(input logic [2:0] sel);
    return (sel == 3'd1) || (sel == 3'd2) || (sel == 3'd3);
  endfunction

  // Divider wrap value: the last count before the next step.
  function automatic logic [1:0] step_last(input logic [1:0] lvl);
    logic [1:0] last;
    case (lvl)
      LVL_EASY:   last = 2'(EASY_PERIOD - 1);
      LVL_NORMAL: last = 2'(NORMAL_PERIOD - 1);
      LVL_HARD:   last = 2'(HARD_PERIOD - 1);
      default:    last = 2'd0;
    endcase
    return last;
  endfunction

endpackage

// File: rtl/stage_sequencer_beat_divider.sv
// Divides beat_tick down to the per-level step rate; a step fires on the
// beat where the count is 0, so the first beat after a clear always steps.
module beat_divider
  import stage_sequencer_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       beat_tick,
  input  logic [1:0] level,
  input  logic       hold,
  output logic       step
);

  logic [1:0] div_cnt;
  logic [1:0] last;

  assign last = step_last(level);
  assign step = beat_tick && !hold && (div_cnt == 2'd0);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      div_cnt <= 2'd0;
    end else if (beat_tick && !hold) begin
      div_cnt <= (div_cnt == last) ? 2'd0 : div_cnt + 2'd1;
    end
  end

endmodule

// File: rtl/stage_sequencer.sv
// Stage sequencer: countdown, scripted enemy spawning paced by beats,
// pause handling, drain period and result hand-off. All outputs registered.
module stage_sequencer
  import stage_sequencer_pkg::*;
#(
  parameter logic [7:0] SCRIPT_LEN      = 8'd200,
  parameter int         COUNTDOWN_BEATS = 3,
  parameter int         DRAIN_BEATS     = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [2:0] level_sel,
  input  logic       pause,
  input  logic       beat_tick,
  input  logic [3:0] life,
  input  logic [3:0] script_data,
  output logic [2:0] state,
  output logic [7:0] script_addr,
  output logic [3:0] spawn,
  output logic [1:0] countdown,
  output logic       gameend
);

  localparam logic [1:0] CD_LOAD    = 2'(COUNTDOWN_BEATS);
  localparam logic [7:0] DRAIN_LAST = 8'(DRAIN_BEATS - 1);
  localparam logic [7:0] ADDR_LAST  = SCRIPT_LEN - 8'd1;

  stage_state_e cur_st, nxt_st;

  logic [1:0] level_q;
  logic [7:0] next_addr;
  logic       done_q;
  logic [7:0] drain_cnt;
  logic       pend_q;

  logic       step;
  logic       hold;
  logic       div_clear;
  logic       stage_begin;
  logic       drain_end;
  logic       drain_inc;
  logic       gameend_d;
  logic       life_out;

  assign life_out    = (life == 4'd0);
  assign stage_begin = (cur_st == ST_IDLE) && (nxt_st == ST_COUNTDOWN);
  assign div_clear   = (cur_st == ST_COUNTDOWN) && (nxt_st == ST_PLAY);
  // Steps stop once the last address has been issued; only drain remains.
  assign hold        = (cur_st != ST_PLAY) || pause || life_out || done_q;
  assign drain_end   = (cur_st == ST_PLAY) && done_q && beat_tick && (drain_cnt == DRAIN_LAST);
  assign drain_inc   = (cur_st == ST_PLAY) && done_q && beat_tick && !pause && !life_out && !drain_end;
  assign gameend_d   = (nxt_st == ST_RESULT) && (cur_st != ST_RESULT);
  assign state       = cur_st;

  beat_divider u_beat_divider (
    .clk       (clk),
    .rst       (rst),
    .clear     (div_clear),
    .beat_tick (beat_tick),
    .level     (level_q),
    .hold      (hold),
    .step      (step)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_st <= ST_IDLE;
    end else begin
      cur_st <= nxt_st;
    end
  end

  always_comb begin
    nxt_st = cur_st;
    case (cur_st)
      ST_IDLE: begin
        if (start && level_valid(level_sel)) nxt_st = ST_COUNTDOWN;
      end
      ST_COUNTDOWN: begin
        if (beat_tick && (countdown == 2'd1)) nxt_st = ST_PLAY;
      end
      ST_PLAY: begin
        if (life_out)       nxt_st = ST_RESULT;
        else if (drain_end) nxt_st = ST_RESULT;
        else if (pause)     nxt_st = ST_PAUSE;
      end
      ST_PAUSE: begin
        if (life_out)   nxt_st = ST_RESULT;
        else if (pause) nxt_st = ST_PLAY;
      end
      ST_RESULT: begin
        if (start) nxt_st = ST_IDLE;
      end
      default: nxt_st = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      level_q     <= 2'd0;
      script_addr <= 8'd0;
      next_addr   <= 8'd0;
      done_q      <= 1'b0;
      drain_cnt   <= 8'd0;
      pend_q      <= 1'b0;
      spawn       <= 4'd0;
      countdown   <= 2'd0;
      gameend     <= 1'b0;
    end else begin
      gameend <= gameend_d;
      // ROM data for an address issued last cycle is valid now.
      spawn   <= pend_q ? script_data : 4'd0;
      pend_q  <= step;

      if (stage_begin) begin
        level_q     <= level_sel[1:0];
        countdown   <= CD_LOAD;
        script_addr <= 8'd0;
        next_addr   <= 8'd0;
        done_q      <= 1'b0;
        drain_cnt   <= 8'd0;
      end else begin
        if (cur_st == ST_COUNTDOWN && beat_tick && countdown != 2'd0) begin
          countdown <= countdown - 2'd1;
        end
        if (step) begin
          script_addr <= next_addr;
          next_addr   <= next_addr + 8'd1;
          if (next_addr == ADDR_LAST) done_q <= 1'b1;
        end
        if (drain_inc) begin
          drain_cnt <= drain_cnt + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_stage_sequencer.sv
// Scoreboard bench for stage_sequencer: expected spawns queued as beats are
// driven, checked when the DUT emits them; FSM/outputs checked at key points.
module tb_stage_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [2:0] level_sel;
  logic       pause;
  logic       beat_tick;
  logic [3:0] life;
  logic [3:0] script_data;
  logic [2:0] state;
  logic [7:0] script_addr;
  logic [3:0] spawn;
  logic [1:0] countdown;
  logic       gameend;

  logic [3:0]  rom [256];
  logic [11:0] exp_q [$];
  logic [7:0]  exp_addr;
  int          total = 0;
  int          bad = 0;
  int          spawn_cnt = 0;
  int          ge_cnt = 0;
  int          sc0;
  int          ge0;

  always #5 clk = ~clk;

  assign script_data = rom[script_addr];

  stage_sequencer #(
    .SCRIPT_LEN      (8'd4),
    .COUNTDOWN_BEATS (3),
    .DRAIN_BEATS     (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .level_sel   (level_sel),
    .pause       (pause),
    .beat_tick   (beat_tick),
    .life        (life),
    .script_data (script_data),
    .state       (state),
    .script_addr (script_addr),
    .spawn       (spawn),
    .countdown   (countdown),
    .gameend     (gameend)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic tick(input bit exp_step, input int post);
    if (exp_step) begin
      exp_q.push_back({exp_addr, rom[exp_addr]});
      exp_addr++;
    end
    beat_tick = 1'b1;
    cyc();
    beat_tick = 1'b0;
    repeat (post) cyc();
  endtask

  task automatic start_stage(input logic [2:0] lvl);
    level_sel = lvl;
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  // Spawn monitor: every non-zero spawn cycle must match the queue head.
  always @(negedge clk) begin
    if (!rst) begin
      if (gameend) ge_cnt++;
      if (spawn != 4'd0) begin
        spawn_cnt++;
        if (exp_q.size() == 0) begin
          chk("spawn_unexpected", {20'd0, script_addr, spawn}, 32'd0);
        end else begin
          chk("spawn", {20'd0, script_addr, spawn}, {20'd0, exp_q.pop_front()});
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 4'((i % 15) + 1);
    rst = 1'b1; start = 1'b0; level_sel = 3'd0; pause = 1'b0;
    beat_tick = 1'b0; life = 4'd3; exp_addr = 8'd0;
    repeat (2) cyc();
    chk("rst_state", state, 0);
    chk("rst_addr", script_addr, 0);
    chk("rst_spawn", spawn, 0);
    chk("rst_cd", countdown, 0);
    chk("rst_gameend", gameend, 0);
    rst = 1'b0;
    cyc();

    start_stage(3'd5);
    chk("bad_level_idle", state, 0);

    // Easy stage
    start_stage(3'd1);
    chk("cd_state", state, 1);
    chk("cd_load", countdown, 3);
    tick(0, 2);
    chk("cd_2", countdown, 2);
    tick(0, 2);
    chk("cd_1", countdown, 1);
    chk("cd_still", state, 1);
    tick(0, 2);
    chk("play_entry", state, 2);
    chk("cd_zero", countdown, 0);

    sc0 = spawn_cnt;
    tick(1, 2); tick(0, 2); tick(0, 2); tick(0, 2);
    tick(1, 2); tick(0, 2); tick(0, 2); tick(0, 2);
    chk("easy_addr", script_addr, 1);
    chk("easy_spawns", spawn_cnt - sc0, 2);

    // pause coincident with a due step
    pause = 1'b1; beat_tick = 1'b1;
    cyc();
    pause = 1'b0; beat_tick = 1'b0;
    repeat (2) cyc();
    chk("pause_enter", state, 3);
    repeat (5) tick(0, 2);
    chk("pause_addr_hold", script_addr, 1);
    chk("pause_state_hold", state, 3);
    pause = 1'b1;
    cyc();
    pause = 1'b0;
    chk("pause_exit", state, 2);
    tick(1, 2);
    chk("resume_step", script_addr, 2);

    // life lost on the beat where a step is due
    tick(0, 2); tick(0, 2); tick(0, 2);
    ge0 = ge_cnt;
    life = 4'd0; beat_tick = 1'b1;
    cyc();
    beat_tick = 1'b0;
    chk("life_result", state, 4);
    chk("life_gameend", gameend, 1);
    chk("life_nospawn", spawn, 0);
    cyc();
    life = 4'd3;
    chk("life_gameend_pulse", gameend, 0);
    chk("life_addr", script_addr, 2);
    cyc();
    chk("life_ge_count", ge_cnt - ge0, 1);
    chk("life_q_empty", exp_q.size(), 0);
    start_stage(3'd0);
    chk("result_to_idle", state, 0);

    // Hard stage: 4-step script then 8-beat drain
    exp_addr = 8'd0;
    start_stage(3'd3);
    repeat (3) tick(0, 2);
    chk("hard_play", state, 2);
    repeat (4) tick(1, 2);
    chk("hard_last_addr", script_addr, 3);
    ge0 = ge_cnt;
    repeat (7) tick(0, 2);
    chk("drain_7", state, 2);
    chk("no_wrap", script_addr, 3);
    tick(0, 0);
    chk("drain_result", state, 4);
    chk("drain_gameend", gameend, 1);
    repeat (3) cyc();
    chk("drain_ge_count", ge_cnt - ge0, 1);
    chk("hard_q_empty", exp_q.size(), 0);
    start_stage(3'd0);

    // Normal stage: pending spawn survives a pause, then reset mid-read
    exp_addr = 8'd0;
    start_stage(3'd2);
    repeat (3) tick(0, 2);
    tick(1, 2); tick(0, 2); tick(1, 2); tick(0, 2);
    tick(1, 0);
    pause = 1'b1;
    cyc();
    pause = 1'b0;
    chk("norm_pause", state, 3);
    repeat (2) cyc();
    chk("pending_spawn_out", exp_q.size(), 0);
    pause = 1'b1;
    cyc();
    pause = 1'b0;
    chk("norm_resume", state, 2);
    tick(0, 2);
    beat_tick = 1'b1;
    cyc();
    beat_tick = 1'b0;
    chk("norm_last_addr", script_addr, 3);
    rst = 1'b1;
    cyc();
    chk("mid_rst_state", state, 0);
    chk("mid_rst_addr", script_addr, 0);
    chk("mid_rst_spawn", spawn, 0);
    chk("mid_rst_cd", countdown, 0);
    chk("mid_rst_gameend", gameend, 0);
    rst = 1'b0;
    cyc();
    chk("post_rst_spawn", spawn, 0);
    pause = 1'b1;
    cyc();
    pause = 1'b0;
    chk("pause_idle_ignored", state, 0);
    repeat (2) cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stage_sequencer.md
STAGE_SEQUENCER -- requirements
Module: stage_sequencer

Interface
REQ-001 Parameter SCRIPT_LEN, default 8'd200: number of script steps per stage.
REQ-002 Parameter COUNTDOWN_BEATS, default 3: beats spent in COUNTDOWN.
REQ-003 Parameter DRAIN_BEATS, default 8: beats after the last spawn before RESULT.
REQ-004 clk  input  1  system clock; single clock domain.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 start  input  1  one-cycle pulse; begins a stage, or leaves RESULT.
REQ-007 level_sel  input  3  requested level: 1 easy, 2 normal, 3 hard; others invalid.
REQ-008 pause  input  1  one-cycle pulse; toggles PLAY/PAUSE.
REQ-009 beat_tick  input  1  one-cycle beat strobe, synchronous to clk.
REQ-010 life  input  4  current player lives.
REQ-011 script_data  input  4  lane mask from script ROM; valid 1 cycle after script_addr changes.
REQ-012 state  output  3  current FSM state.
REQ-013 script_addr  output  8  script ROM address.
REQ-014 spawn  output  4  one-cycle lane mask of enemies to spawn.
REQ-015 countdown  output  2  beats remaining in COUNTDOWN; 0 elsewhere.
REQ-016 gameend  output  1  one-cycle pulse on RESULT entry.

Function
REQ-017 The block SHALL implement states IDLE=0, COUNTDOWN=1, PLAY=2, PAUSE=3, RESULT=4.
REQ-018 IDLE -> COUNTDOWN on start with level_sel in 1..3; the block SHALL latch level_sel and ignore start with an invalid level.
REQ-019 On COUNTDOWN entry, countdown SHALL load COUNTDOWN_BEATS and decrement on each beat_tick; the beat_tick that takes it to 0 SHALL move to PLAY.
REQ-020 Step period in PLAY: easy 4 beats, normal 2, hard 1. Each step SHALL issue the next script_addr, starting at 0.
REQ-021 The cycle after an address is issued, spawn SHALL equal script_data for exactly one cycle. spawn SHALL be 0 at all other times.
REQ-022 The step issuing address SCRIPT_LEN-1 SHALL be the last one. Afterwards, DRAIN_BEATS beat_ticks SHALL elapse before the move to RESULT.
REQ-023 pause in PLAY -> PAUSE; pause in PAUSE -> PLAY. The beat divider, drain counter and script_addr SHALL hold in PAUSE. pause in any other state SHALL be ignored.
REQ-024 A pending spawn (address issued the previous cycle) SHALL still be output when pause arrives on that cycle.
REQ-025 life==0 in PLAY or PAUSE SHALL move to RESULT on the next edge. Priority: life==0 > script end > pause > beat step.
REQ-026 beat_tick and pause in the same PLAY cycle: pause wins and the step SHALL NOT occur.
REQ-027 RESULT -> IDLE on start. gameend SHALL pulse only on the first RESULT cycle.
REQ-028 script_addr SHALL never exceed SCRIPT_LEN-1 and SHALL NOT wrap.
REQ-029 The beat divider SHALL be 2 bits and SHALL reset to 0 on PLAY entry from COUNTDOWN. The first step SHALL occur on the first beat_tick in PLAY.
REQ-030 All outputs SHALL be registered.

Reset
REQ-031 With rst high at a clk edge, the block SHALL set state=IDLE, script_addr=0, spawn=0, countdown=0, gameend=0, level latch=0, and clear all counters.
REQ-032 rst SHALL take priority over every input in any state, including mid-stage and during a pending ROM read.

Structure
REQ-033 State encodings, level codes and per-level step periods SHALL live in a shared package used by the top-level FSM and judge.
REQ-034 One sub-module, beat_divider, SHALL take beat_tick, level and hold, and output the step strobe.
REQ-035 The script ROM SHALL be external to this block.

Verification
REQ-036 Reset, then start with level_sel=1 -> COUNTDOWN with countdown=3; after 3 beat_ticks -> state=PLAY.
REQ-037 Easy level, 8 beat_ticks in PLAY -> script_addr steps 0 then 1; spawn equals ROM data for 2 cycles total.
REQ-038 Hard level, SCRIPT_LEN=4 -> addresses 0..3, then 8 beats later gameend pulses once and state=RESULT.
REQ-039 pause coincident with beat_tick -> state=PAUSE, no step; 5 beat_ticks -> script_addr unchanged; pause -> PLAY.
REQ-040 life driven to 0 in the cycle a step is due -> state=RESULT next edge, spawn stays 0, gameend=1 for one cycle.
REQ-041 start with level_sel=5 in IDLE -> remains IDLE; rst asserted in PLAY -> all outputs 0 next edge.
